// File: rtl/overflow_monitor.sv
// Overflow statistics: sticky per-bit flags plus two windowed, saturating
// overflow counters with end-of-window snapshots and a 4-phase clear handshake.

module overflow_monitor_chan #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_i,
  input  logic [1:0]           ov,
  input  logic                 step,
  input  logic                 term,
  input  logic                 clr,
  output logic [CNT_WIDTH-1:0] count
);
  logic [CNT_WIDTH-1:0] acc;
  logic [1:0]           inc;
  logic [CNT_WIDTH:0]   sum;
  logic [CNT_WIDTH-1:0] sat;

  // One extra sum bit catches the carry; inc <= 2 cannot overflow it.
  assign inc = {1'b0, ov[0]} + {1'b0, ov[1]};
  assign sum = {1'b0, acc} + (CNT_WIDTH+1)'(inc);
  assign sat = sum[CNT_WIDTH] ? '1 : sum[CNT_WIDTH-1:0];

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      acc   <= '0;
      count <= '0;
    end else if (clr) begin
      acc   <= '0;
      count <= '0;
    end else if (step) begin
      if (term) begin
        count <= sat;
        acc   <= '0;
      end else begin
        acc   <= sat;
      end
    end
  end
endmodule

module overflow_monitor #(
  parameter int WINDOW_LEN = 1024,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst_i,
  input  logic                 enable_i,
  input  logic [3:0]           overflow_i,
  input  logic                 clear_req_i,
  output logic                 clear_ack_o,
  output logic [3:0]           sticky_o,
  output logic [CNT_WIDTH-1:0] ovf_count_1_o,
  output logic [CNT_WIDTH-1:0] ovf_count_2_o,
  output logic                 window_done_o
);
  localparam int NUM_CH = 2;
  localparam int WC_W   = $clog2(WINDOW_LEN);
  localparam logic [WC_W-1:0] LAST = WC_W'(WINDOW_LEN-1);

  typedef enum logic [1:0] {RUN, CLEAR, WAIT_REL} state_t;

  state_t                             state;
  logic [3:0]                         ov_r;
  logic                               en_r;
  logic [WC_W-1:0]                    wcnt;
  logic                               step, term, clr;
  logic [NUM_CH-1:0][1:0]             ov_pair;
  logic [NUM_CH-1:0][CNT_WIDTH-1:0]   counts;

  // A pending clear request pre-empts counting, including a terminal cycle.
  assign step    = (state == RUN) && !clear_req_i && en_r;
  assign term    = step && (wcnt == LAST);
  assign clr     = (state == CLEAR);
  assign ov_pair = ov_r;

  generate
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      overflow_monitor_chan #(.CNT_WIDTH(CNT_WIDTH)) u_ch (
        .clk   (clk),
        .rst_i (rst_i),
        .ov    (ov_pair[g]),
        .step  (step),
        .term  (term),
        .clr   (clr),
        .count (counts[g])
      );
    end
  endgenerate

  assign ovf_count_1_o = counts[0];
  assign ovf_count_2_o = counts[1];

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state         <= RUN;
      ov_r          <= '0;
      en_r          <= 1'b0;
      wcnt          <= '0;
      sticky_o      <= '0;
      clear_ack_o   <= 1'b0;
      window_done_o <= 1'b0;
    end else begin
      ov_r          <= overflow_i;
      en_r          <= enable_i;
      window_done_o <= term;
      case (state)
        RUN: begin
          if (clear_req_i) begin
            state <= CLEAR;
          end else if (en_r) begin
            sticky_o <= sticky_o | ov_r;
            wcnt     <= (wcnt == LAST) ? '0 : wcnt + WC_W'(1);
          end
        end
        CLEAR: begin
          wcnt        <= '0;
          sticky_o    <= '0;
          clear_ack_o <= 1'b1;
          state       <= WAIT_REL;
        end
        WAIT_REL: begin
          if (!clear_req_i) begin
            clear_ack_o <= 1'b0;
            state       <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end
endmodule
